// File: rtl/dcache_resp_pkg.sv
// Shared definitions for the data-cache responder.
// Holds the main FSM encoding, the recorded cache-op code values and
// the width helpers used to size strobes from the data width.
package dcache_resp_pkg;

    localparam int unsigned ADDR_W_DEF = 32;
    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned BYTE_W     = 8;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RD_ISSUE = 3'd1,
        S_RD_WAIT  = 3'd2,
        S_WR_ISSUE = 3'd3,
        S_CACOP    = 3'd4
    } state_e;

    // Cache-op codes; the responder only records them for debug.
    localparam logic [1:0] CACOP_IDX_INIT  = 2'd0;
    localparam logic [1:0] CACOP_IDX_INV   = 2'd1;
    localparam logic [1:0] CACOP_HIT_INV   = 2'd2;
    localparam logic [1:0] CACOP_HIT_WBINV = 2'd3;

    function automatic int unsigned strb_w(input int unsigned data_w);
        return data_w / BYTE_W;
    endfunction

endpackage

// File: rtl/dcache_store_buf.sv
// Single-entry posted store buffer.
// Ports:
//   clk, reset            clock, async active-low reset
//   load                  capture load_addr/wstrb/wdata and become valid
//   mem_gnt               memory accepted the drain write; entry empties
//   sb_valid              entry holds an uncommitted store
//   mem_req/we/addr/...   drain request, all zero while empty
module dcache_store_buf
    import dcache_resp_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      load,
    input  logic [ADDR_W-1:0]         load_addr,
    input  logic [strb_w(DATA_W)-1:0] load_wstrb,
    input  logic [DATA_W-1:0]         load_wdata,
    input  logic                      mem_gnt,
    output logic                      sb_valid,
    output logic                      mem_req,
    output logic                      mem_we,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [strb_w(DATA_W)-1:0] mem_wstrb,
    output logic [DATA_W-1:0]         mem_wdata
);
    localparam int STRB_W = strb_w(DATA_W);

    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [STRB_W-1:0] wstrb_q, wstrb_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    always_comb begin
        valid_d = valid_q;
        addr_d  = addr_q;
        wstrb_d = wstrb_q;
        wdata_d = wdata_q;
        // Loading only happens while empty, so load and drain never overlap.
        if (load) begin
            valid_d = 1'b1;
            addr_d  = load_addr;
            wstrb_d = load_wstrb;
            wdata_d = load_wdata;
        end else if (valid_q && mem_gnt) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            wstrb_q <= '0;
            wdata_q <= '0;
        end else begin
            valid_q <= valid_d;
            addr_q  <= addr_d;
            wstrb_q <= wstrb_d;
            wdata_q <= wdata_d;
        end
    end

    assign sb_valid  = valid_q;
    assign mem_req   = valid_q;
    assign mem_we    = valid_q;
    assign mem_addr  = valid_q ? addr_q  : '0;
    assign mem_wstrb = valid_q ? wstrb_q : '0;
    assign mem_wdata = valid_q ? wdata_q : '0;

endmodule

// File: rtl/dcache_responder.sv
// Data-side responder between the AGU dcache buses and a req/gnt/rvalid
// memory port. One request at a time; cached stores are posted into a
// single-entry buffer, loads / uncached stores / cache-ops block the FSM.
// Ports: clk, reset (async active-low), flush; req_* request bus with
// req_ready; resp_ok/resp_rdata and cacop_ok responses; mem_* memory port.
//
// state      | meaning
// IDLE       | waiting for a request (or draining the store buffer)
// RD_ISSUE   | load request on memory port, waiting for gnt
// RD_WAIT    | load granted, waiting for rvalid
// WR_ISSUE   | uncached store on memory port, waiting for gnt
// CACOP      | cache-op completion cycle, no memory traffic
module dcache_responder
    import dcache_resp_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_we,
    input  logic [ADDR_W-1:0]         req_addr,
    input  logic [strb_w(DATA_W)-1:0] req_wstrb,
    input  logic [DATA_W-1:0]         req_wdata,
    input  logic                      req_uncached,
    input  logic                      req_cacop,
    input  logic [1:0]                req_cacop_code,
    output logic                      resp_ok,
    output logic [DATA_W-1:0]         resp_rdata,
    output logic                      cacop_ok,
    output logic                      mem_req,
    output logic                      mem_we,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [strb_w(DATA_W)-1:0] mem_wstrb,
    output logic [DATA_W-1:0]         mem_wdata,
    input  logic                      mem_gnt,
    input  logic                      mem_rvalid,
    input  logic [DATA_W-1:0]         mem_rdata
);
    localparam int STRB_W = strb_w(DATA_W);

    state_e            state_q, state_d;
    logic              kill_q, kill_d;
    logic              resp_ok_q, resp_ok_d;
    logic              rdy_en_q;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [STRB_W-1:0] wstrb_q, wstrb_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [1:0]        code_q, code_d;

    logic              accept, sb_load, kill_now;
    logic [ADDR_W-1:0] req_addr_word;
    logic              sb_valid, sb_req, sb_we;
    logic [ADDR_W-1:0] sb_addr;
    logic [STRB_W-1:0] sb_wstrb;
    logic [DATA_W-1:0] sb_wdata;

    // rdy_en_q keeps req_ready low while reset is asserted.
    assign req_ready     = rdy_en_q && (state_q == S_IDLE) && !sb_valid;
    assign accept        = req_valid && req_ready && !flush;
    assign kill_now      = kill_q || flush;
    assign req_addr_word = {req_addr[ADDR_W-1:2], 2'b00};

    always_comb begin
        state_d   = state_q;
        resp_ok_d = 1'b0;
        rdata_d   = rdata_q;
        addr_d    = addr_q;
        wstrb_d   = wstrb_q;
        wdata_d   = wdata_q;
        code_d    = code_q;
        sb_load   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    addr_d  = req_addr_word;
                    wstrb_d = req_wstrb;
                    wdata_d = req_wdata;
                    if (req_cacop) begin
                        state_d = S_CACOP;
                        code_d  = req_cacop_code;
                    end else if (!req_we) begin
                        state_d = S_RD_ISSUE;
                    end else if (req_uncached) begin
                        state_d = S_WR_ISSUE;
                    end else begin
                        sb_load   = 1'b1;
                        resp_ok_d = 1'b1;
                    end
                end
            end
            S_RD_ISSUE: begin
                if (mem_gnt) begin
                    // rvalid may arrive together with gnt
                    if (mem_rvalid) begin
                        state_d   = S_IDLE;
                        rdata_d   = mem_rdata;
                        resp_ok_d = !kill_now;
                    end else begin
                        state_d = S_RD_WAIT;
                    end
                end
            end
            S_RD_WAIT: begin
                if (mem_rvalid) begin
                    state_d   = S_IDLE;
                    rdata_d   = mem_rdata;
                    resp_ok_d = !kill_now;
                end
            end
            S_WR_ISSUE: begin
                if (mem_gnt) begin
                    state_d   = S_IDLE;
                    resp_ok_d = !kill_now;
                end
            end
            S_CACOP:  state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        kill_d = (state_q != S_IDLE) && (state_d != S_IDLE) && kill_now;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            kill_q    <= 1'b0;
            resp_ok_q <= 1'b0;
            rdy_en_q  <= 1'b0;
            rdata_q   <= '0;
            addr_q    <= '0;
            wstrb_q   <= '0;
            wdata_q   <= '0;
            code_q    <= '0;
        end else begin
            state_q   <= state_d;
            kill_q    <= kill_d;
            resp_ok_q <= resp_ok_d;
            rdy_en_q  <= 1'b1;
            rdata_q   <= rdata_d;
            addr_q    <= addr_d;
            wstrb_q   <= wstrb_d;
            wdata_q   <= wdata_d;
            code_q    <= code_d;
        end
    end

    dcache_store_buf #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_sb (
        .clk       (clk),
        .reset     (reset),
        .load      (sb_load),
        .load_addr (req_addr_word),
        .load_wstrb(req_wstrb),
        .load_wdata(req_wdata),
        .mem_gnt   (mem_gnt),
        .sb_valid  (sb_valid),
        .mem_req   (sb_req),
        .mem_we    (sb_we),
        .mem_addr  (sb_addr),
        .mem_wstrb (sb_wstrb),
        .mem_wdata (sb_wdata)
    );

    // The buffer only holds data while the FSM is idle, so the two
    // masters never compete for the port.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wstrb = '0;
        mem_wdata = '0;
        if (sb_valid) begin
            mem_req   = sb_req;
            mem_we    = sb_we;
            mem_addr  = sb_addr;
            mem_wstrb = sb_wstrb;
            mem_wdata = sb_wdata;
        end else if (state_q == S_RD_ISSUE) begin
            mem_req  = 1'b1;
            mem_addr = addr_q;
        end else if (state_q == S_WR_ISSUE) begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = addr_q;
            mem_wstrb = wstrb_q;
            mem_wdata = wdata_q;
        end
    end

    assign resp_ok    = resp_ok_q;
    assign resp_rdata = rdata_q;
    assign cacop_ok   = (state_q == S_CACOP);

endmodule
